// File: rtl/toggle_cover_pkg.sv
// Shared definitions for the toggle coverage detector.
package toggle_cover_pkg;

    // PRIME: no previous sample held yet; RUN: edges can be detected.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 21;

endpackage

// File: rtl/toggle_cover_bit.sv
// Per-bit toggle tracker: edge detection, seen flags, done flag and
// the registered one-cycle completion pulse.
module toggle_cover_bit #(
    parameter int unsigned ONCE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic capture,
    input  logic update,
    input  logic sig,
    output logic valid,
    output logic done,
    output logic newly_done
);

    logic prev;
    logic seen_rise;
    logic seen_fall;
    logic rise;
    logic fall;
    logic got_rise;
    logic got_fall;
    logic complete;
    logic pulse;

    // Edge detection and completion for the sample being taken this cycle.
    always_comb begin
        rise       = ~prev & sig;
        fall       = prev & ~sig;
        got_rise   = seen_rise | rise;
        got_fall   = seen_fall | fall;
        complete   = update & got_rise & got_fall;
        pulse      = (ONCE != 0) ? (complete & ~done) : complete;
        newly_done = complete & ~done;
    end

    // Tracking state; reset beats clear, clear beats any sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev      <= 1'b0;
            seen_rise <= 1'b0;
            seen_fall <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
        end else if (clear) begin
            seen_rise <= 1'b0;
            seen_fall <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= pulse;
            if (capture) begin
                prev <= sig;
            end else if (update) begin
                prev <= sig;
                // In repeat mode a completed pair re-arms the bit.
                if (complete && (ONCE == 0)) begin
                    seen_rise <= 1'b0;
                    seen_fall <= 1'b0;
                end else begin
                    seen_rise <= got_rise;
                    seen_fall <= got_fall;
                end
                done <= done | complete;
            end
        end
    end

endmodule

// File: rtl/toggle_cover_detect.sv
// Toggle coverage detector: priming FSM, per-bit trackers and the
// covered-bit counter.
module toggle_cover_detect
    import toggle_cover_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned ONCE  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           sig,
    input  logic                       sample_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           valid,
    output logic [$clog2(WIDTH+1)-1:0] covered_cnt,
    output logic                       all_covered
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_t          state_q;
    state_t          state_d;
    logic            capture;
    logic            update;
    logic [WIDTH-1:0] done;
    logic [WIDTH-1:0] newly_done;
    logic [CW-1:0]   add;
    logic [CW-1:0]   cnt_next;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-sample strobes; clear discards the sample.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        update  = 1'b0;
        if (clear) begin
            state_d = PRIME;
        end else if (sample_en) begin
            if (state_q == PRIME) begin
                capture = 1'b1;
                state_d = RUN;
            end else begin
                update = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        toggle_cover_bit #(
            .ONCE(ONCE)
        ) u_bit (
            .clock     (clock),
            .reset     (reset),
            .clear     (clear),
            .capture   (capture),
            .update    (update),
            .sig       (sig[g]),
            .valid     (valid[g]),
            .done      (done[g]),
            .newly_done(newly_done[g])
        );
    end

    // Popcount of bits covered for the first time by this sample.
    always_comb begin
        add = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            add = add + CW'(newly_done[i]);
        end
        cnt_next = covered_cnt + add;
    end

    // Counter and full flag, registered alongside valid.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            covered_cnt <= '0;
            all_covered <= 1'b0;
        end else begin
            covered_cnt <= cnt_next;
            all_covered <= (cnt_next == FULL);
        end
    end

endmodule

// File: doc/toggle_cover_detect.md
TOGGLE_COVER_DETECT -- requirements
Module: toggle_cover_detect

Interface
REQ-001 Parameter WIDTH, default 21, number of monitored signal bits.
REQ-002 Parameter ONCE, default 1; 1 = report each bit's first complete toggle only, 0 = report every complete toggle.
REQ-003 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port sig  input  WIDTH  monitored signal vector.
REQ-006 Port sample_en  input  1  qualifies sig as a valid sample this cycle.
REQ-007 Port clear  input  1  synchronous re-arm of all coverage state.
REQ-008 Port valid  output  WIDTH  per-bit one-cycle toggle-complete pulse; feeds the downstream toggle cover reporter.
REQ-009 Port covered_cnt  output  $clog2(WIDTH+1)  number of bits that have completed at least one toggle.
REQ-010 Port all_covered  output  1  high when covered_cnt equals WIDTH.

Function
REQ-011 The FSM SHALL have two states: PRIME (no previous sample held) and RUN.
REQ-012 In PRIME with sample_en=1, the block SHALL capture prev<=sig, move to RUN, and produce no valid pulse.
REQ-013 In RUN with sample_en=1, the block SHALL compute rise=~prev&sig and fall=prev&~sig per bit, then update prev<=sig.
REQ-014 The block SHALL set seen_rise[i] on rise[i] and seen_fall[i] on fall[i].
REQ-015 Bit i SHALL complete a toggle in the cycle where (seen_rise[i]|rise[i]) and (seen_fall[i]|fall[i]) both hold after that sample.
REQ-016 valid[i] SHALL be registered, asserting exactly one cycle after the completing sample and lasting one cycle.
REQ-017 With ONCE=1, bit i SHALL set done[i] on completion and SHALL NOT pulse valid[i] again until clear or reset.
REQ-018 With ONCE=0, completion SHALL clear seen_rise[i]/seen_fall[i], so valid[i] pulses again on every subsequent rise+fall pair; done[i] is still set.
REQ-019 With sample_en=0, prev, seen and done SHALL hold, and valid SHALL be all-zero in the following cycle.
REQ-020 covered_cnt SHALL increase by the popcount of bits whose done transitions 0->1 in that cycle, with the same one-cycle latency as valid; it never exceeds WIDTH.
REQ-021 all_covered SHALL be registered and equal (covered_cnt==WIDTH).
REQ-022 clear=1 SHALL zero seen_rise, seen_fall, done, covered_cnt, all_covered and valid next cycle, and return the FSM to PRIME.
REQ-023 clear SHALL take priority over sample_en in the same cycle, and that sample SHALL be discarded.
REQ-024 Multiple bits completing in one sample SHALL all pulse in the same valid cycle.

Reset
REQ-025 While reset=1, the block SHALL set FSM=PRIME and prev, seen_rise, seen_fall, done, valid, covered_cnt and all_covered to 0.
REQ-026 Reset SHALL take priority over clear and sample_en.
REQ-027 Reset asserted mid-operation SHALL abort any pending pulse, with valid=0 in the cycle after reset is sampled.

Structure
REQ-028 A shared package toggle_cover_pkg SHALL hold the FSM state enum (PRIME, RUN) and the WIDTH default constant.
REQ-029 Per-bit tracking (prev, seen_rise, seen_fall, done, valid) SHALL live in one sub-module, toggle_cover_bit, instantiated WIDTH times.
REQ-030 The top level SHALL hold the FSM, the popcount/covered_cnt logic and the all_covered logic.

Verification
REQ-031 Bench SHALL cover, WIDTH=21, ONCE=1: after reset, samples sig=0, then 0x1, then 0x0 -> no pulse after the first sample; valid=0x000001 one cycle after the third sample; covered_cnt=1.
REQ-032 Bench SHALL cover, ONCE=1: sig=0 -> 0x1FFFFF -> 0 -> 0x1FFFFF -> 0 -> a single valid=0x1FFFFF pulse; covered_cnt=21; all_covered=1; no further pulses.
REQ-033 Bench SHALL cover, ONCE=0: bit 3 toggled 0->1->0 twice -> valid[3] pulses twice; covered_cnt stays 1.
REQ-034 Bench SHALL cover: sample_en=0 while sig toggles bit 5 -> no valid pulse and no state change.
REQ-035 Bench SHALL cover: clear and sample_en asserted together, with bit 0 seen_rise set -> state zeroed and FSM=PRIME; the next sample only primes, with no pulse.
REQ-036 Bench SHALL cover: reset asserted in the cycle of a completing sample -> valid=0 and covered_cnt=0 in the following cycle.
